tile_packet_loader: RTL and testbench

- Double-buffered ingest stage in front of the tile solver.
- Accepts the typed 32-bit command word stream (3-bit type in bits 31:29, 29-bit payload) and assembles one tile request per packet: output address, zoom level, c_real limbs, c_imag limbs.
- While the solver reads the completed packet from one bank, the next packet loads into the other bank.
- Generalises the single-packet input path to parametrised limb depth and payload width, and adds the bank handshake, limb random access and error reporting.

---
 rtl/tile_packet_loader.sv | 174 +++++++++++++++++
 tb/tb_tile_packet_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_packet_loader.sv
// Double-buffered command-word ingest: assembles tile requests into two banks for the solver.
// Optional TILE_LOADER_ZERO_FILL_EN: rd_data reads as 0 beyond the stored limb count.
module tile_packet_loader #(
  parameter int unsigned LIMB_INDEX_BITS = 6,
  parameter int unsigned PAYLOAD_BITS    = 29
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [31:0]                in_data,
  input  logic                       in_end_of_stream,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PAYLOAD_BITS-1:0]    out_address,
  output logic [PAYLOAD_BITS-1:0]    out_zoom,
  output logic [LIMB_INDEX_BITS:0]   out_real_count,
  output logic [LIMB_INDEX_BITS:0]   out_imag_count,
  input  logic                       rd_sel,
  input  logic [LIMB_INDEX_BITS-1:0] rd_index,
  output logic [PAYLOAD_BITS-1:0]    rd_data,
  output logic [2:0]                 err_flags
);

  localparam int unsigned CNT_W  = LIMB_INDEX_BITS + 1;
  localparam int unsigned DEPTH  = 1 << LIMB_INDEX_BITS;
  localparam int unsigned MEM_AW = LIMB_INDEX_BITS + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  localparam logic [2:0] T_ADDR = 3'd0;
  localparam logic [2:0] T_ZOOM = 3'd1;
  localparam logic [2:0] T_REAL = 3'd2;
  localparam logic [2:0] T_IMAG = 3'd3;
  localparam logic [2:0] T_NOP  = 3'd4;

  typedef enum logic {BANK_EMPTY, BANK_FULL} bank_state_t;

  bank_state_t [1:0]             bank_q, bank_d;
  logic                          wr_bank_q, wr_bank_d;
  logic                          rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]              real_cnt_q, real_cnt_d;
  logic [CNT_W-1:0]              imag_cnt_q, imag_cnt_d;
  logic [1:0][PAYLOAD_BITS-1:0]  addr_q, addr_d;
  logic [1:0][PAYLOAD_BITS-1:0]  zoom_q, zoom_d;
  logic [1:0][CNT_W-1:0]         real_len_q, real_len_d;
  logic [1:0][CNT_W-1:0]         imag_len_q, imag_len_d;
  logic [2:0]                    err_q, err_d;
  logic                          real_we, imag_we;
  logic                          accept, release_bank;
  logic [2:0]                    word_type;
  logic [PAYLOAD_BITS-1:0]       payload;

  logic [PAYLOAD_BITS-1:0] real_mem [0:2*DEPTH-1];
  logic [PAYLOAD_BITS-1:0] imag_mem [0:2*DEPTH-1];
  logic [MEM_AW-1:0]       rd_addr;
  logic [PAYLOAD_BITS-1:0] rd_word;

  assign word_type    = in_data[31:29];
  assign payload      = in_data[PAYLOAD_BITS-1:0];
  assign in_ready     = (bank_q[wr_bank_q] == BANK_EMPTY);
  assign out_valid    = (bank_q[rd_bank_q] == BANK_FULL);
  assign accept       = in_valid && in_ready;
  assign release_bank = out_valid && out_ready;

  assign out_address    = addr_q[rd_bank_q];
  assign out_zoom       = zoom_q[rd_bank_q];
  assign out_real_count = real_len_q[rd_bank_q];
  assign out_imag_count = imag_len_q[rd_bank_q];
  assign err_flags      = err_q;

  // Bank state, word decode, commit and release
  always_comb begin
    bank_d     = bank_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    real_cnt_d = real_cnt_q;
    imag_cnt_d = imag_cnt_q;
    addr_d     = addr_q;
    zoom_d     = zoom_q;
    real_len_d = real_len_q;
    imag_len_d = imag_len_q;
    err_d      = err_q;
    real_we    = 1'b0;
    imag_we    = 1'b0;

    if (accept) begin
      case (word_type)
        T_ADDR: addr_d[wr_bank_q] = payload;
        T_ZOOM: zoom_d[wr_bank_q] = payload;
        T_REAL: begin
          if (real_cnt_q == CNT_MAX) begin
            err_d[0] = 1'b1;
          end else begin
            real_we    = 1'b1;
            real_cnt_d = real_cnt_q + CNT_W'(1);
          end
        end
        T_IMAG: begin
          if (imag_cnt_q == CNT_MAX) begin
            err_d[0] = 1'b1;
          end else begin
            imag_we    = 1'b1;
            imag_cnt_d = imag_cnt_q + CNT_W'(1);
          end
        end
        T_NOP:   ;
        default: err_d[1] = 1'b1;
      endcase

      // Commit uses counts that already include the end-of-stream word itself
      if (in_end_of_stream) begin
        bank_d[wr_bank_q]     = BANK_FULL;
        real_len_d[wr_bank_q] = real_cnt_d;
        imag_len_d[wr_bank_q] = imag_cnt_d;
        if ((real_cnt_d == '0) && (imag_cnt_d == '0)) err_d[2] = 1'b1;
        wr_bank_d  = ~wr_bank_q;
        real_cnt_d = '0;
        imag_cnt_d = '0;
      end
    end

    // Never collides with a commit: commit needs EMPTY, release needs FULL
    if (release_bank) begin
      bank_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bank_q     <= {BANK_EMPTY, BANK_EMPTY};
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      real_cnt_q <= '0;
      imag_cnt_q <= '0;
      addr_q     <= '0;
      zoom_q     <= '0;
      real_len_q <= '0;
      imag_len_q <= '0;
      err_q      <= '0;
    end else begin
      bank_q     <= bank_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      real_cnt_q <= real_cnt_d;
      imag_cnt_q <= imag_cnt_d;
      addr_q     <= addr_d;
      zoom_q     <= zoom_d;
      real_len_q <= real_len_d;
      imag_len_q <= imag_len_d;
      err_q      <= err_d;
    end
  end

  // Limb storage; bank select is the top address bit
  always_ff @(posedge clock) begin
    if (real_we) real_mem[{wr_bank_q, real_cnt_q[LIMB_INDEX_BITS-1:0]}] <= payload;
    if (imag_we) imag_mem[{wr_bank_q, imag_cnt_q[LIMB_INDEX_BITS-1:0]}] <= payload;
  end

  always_comb begin
    rd_addr = {rd_bank_q, rd_index};
    rd_word = rd_sel ? imag_mem[rd_addr] : real_mem[rd_addr];
`ifdef TILE_LOADER_ZERO_FILL_EN
    if (CNT_W'(rd_index) >= (rd_sel ? out_imag_count : out_real_count)) rd_word = '0;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_word;
  end

endmodule

// File: tb/tb_tile_packet_loader.sv
// Scoreboard bench for tile_packet_loader: stimulus queues expectations, a negedge monitor checks them.
module tb_tile_packet_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_end_of_stream = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [28:0] out_address;
  logic [28:0] out_zoom;
  logic [6:0]  out_real_count;
  logic [6:0]  out_imag_count;
  logic        rd_sel = 1'b0;
  logic [5:0]  rd_index = '0;
  logic [28:0] rd_data;
  logic [2:0]  err_flags;

  tile_packet_loader #(.LIMB_INDEX_BITS(6), .PAYLOAD_BITS(29)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_end_of_stream(in_end_of_stream),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_address(out_address), .out_zoom(out_zoom),
    .out_real_count(out_real_count), .out_imag_count(out_imag_count),
    .rd_sel(rd_sel), .rd_index(rd_index), .rd_data(rd_data), .err_flags(err_flags)
  );

  always #5 clock = ~clock;

  localparam int S_IN_READY = 0, S_OUT_VALID = 1, S_ADDR = 2, S_ZOOM = 3,
                 S_RCNT = 4, S_ICNT = 5, S_RD = 6, S_ERR = 7;

  typedef struct {
    int          sig;
    logic [31:0] exp;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] act(input int s);
    case (s)
      S_IN_READY:  return 32'(in_ready);
      S_OUT_VALID: return 32'(out_valid);
      S_ADDR:      return 32'(out_address);
      S_ZOOM:      return 32'(out_zoom);
      S_RCNT:      return 32'(out_real_count);
      S_ICNT:      return 32'(out_imag_count);
      S_RD:        return 32'(rd_data);
      default:     return 32'(err_flags);
    endcase
  endfunction

  // Expected value checked at the coming negedge (lat=0) or lat cycles later
  task automatic expect_at(input int s, input logic [31:0] e, input string nm, input int lat);
    exp_t x;
    x.sig = s; x.exp = e; x.due = cyc + lat; x.name = nm;
    sb.push_back(x);
  endtask

  always @(negedge clock) begin
    int i;
    logic [31:0] a;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        a = act(sb[i].sig);
        n_tests++;
        if (a !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", sb[i].name, a, sb[i].exp);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // Present one word and hold it until the loader accepts it
  task automatic send(input logic [2:0] t, input logic [28:0] p, input logic eos);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = {t, p}; in_end_of_stream = eos;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        break;
      end
    end
    @(posedge clock); #1;
    in_valid = 1'b0; in_end_of_stream = 1'b0;
  endtask

  task automatic rd(input logic sel, input logic [5:0] idx, input logic [31:0] e, input string nm);
    rd_sel = sel; rd_index = idx;
    expect_at(S_RD, e, nm, 1);
    @(posedge clock); #1;
  endtask

  task automatic release_pulse();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    idle(2);
    reset = 1'b0;
    expect_at(S_IN_READY, 1, "rst_in_ready", 0);
    expect_at(S_OUT_VALID, 0, "rst_out_valid", 0);
    expect_at(S_ADDR, 0, "rst_addr", 0);
    expect_at(S_ZOOM, 0, "rst_zoom", 0);
    expect_at(S_RCNT, 0, "rst_rcnt", 0);
    expect_at(S_RD, 0, "rst_rd_data", 0);
    expect_at(S_ERR, 0, "rst_err", 0);
    idle(1);

    // Packet 1 into bank 0, with an idle gap
    send(0, 1, 0); send(1, 2, 0);
    send(2, 3, 0); send(2, 4, 0); send(2, 5, 0);
    send(3, 6, 0); send(3, 7, 0);
    expect_at(S_OUT_VALID, 0, "gap_out_valid", 0);
    expect_at(S_IN_READY, 1, "gap_in_ready", 0);
    idle(3);
    send(3, 8, 0); send(4, 0, 1);
    expect_at(S_OUT_VALID, 1, "p1_out_valid", 0);
    expect_at(S_ADDR, 1, "p1_addr", 0);
    expect_at(S_ZOOM, 2, "p1_zoom", 0);
    expect_at(S_RCNT, 3, "p1_rcnt", 0);
    expect_at(S_ICNT, 3, "p1_icnt", 0);
    expect_at(S_ERR, 0, "p1_err", 0);
    rd(0, 0, 3, "p1_real0"); rd(0, 1, 4, "p1_real1"); rd(0, 2, 5, "p1_real2");
    rd(1, 0, 6, "p1_imag0"); rd(1, 1, 7, "p1_imag1"); rd(1, 2, 8, "p1_imag2");
    release_pulse();
    expect_at(S_OUT_VALID, 0, "p1_released", 0);

    // Back-to-back packets A (bank 1) and B (bank 0) with no release
    send(0, 10, 0); send(1, 11, 0); send(2, 100, 0); send(4, 0, 1);
    send(0, 20, 0); send(1, 21, 0); send(2, 200, 0); send(3, 201, 0); send(3, 202, 1);
    expect_at(S_IN_READY, 0, "both_full_in_ready", 0);
    expect_at(S_ADDR, 10, "both_full_addr", 0);
    // Third packet's first word held off
    in_valid = 1'b1; in_data = {3'd0, 29'd30}; in_end_of_stream = 1'b0;
    idle(3);
    expect_at(S_IN_READY, 0, "held_in_ready", 0);
    expect_at(S_RCNT, 1, "pA_rcnt", 0);
    release_pulse();
    expect_at(S_IN_READY, 1, "after_rel_in_ready", 0);
    expect_at(S_OUT_VALID, 1, "after_rel_out_valid", 0);
    expect_at(S_ADDR, 20, "pB_addr", 0);
    expect_at(S_RCNT, 1, "pB_rcnt", 0);
    expect_at(S_ICNT, 2, "pB_icnt", 0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    send(2, 300, 0); send(3, 301, 0); send(4, 0, 1);
    expect_at(S_IN_READY, 0, "p3_both_full", 0);
    rd(1, 1, 202, "pB_imag1");
    release_pulse();
    expect_at(S_ADDR, 30, "p3_addr_held_word", 0);
    expect_at(S_ICNT, 1, "p3_icnt", 0);
    release_pulse();
    expect_at(S_OUT_VALID, 0, "all_released", 0);

    // Overflow: 66 real limbs into bank 0
    for (int k = 1; k <= 66; k++) send(2, 29'(k), 0);
    send(4, 0, 1);
    expect_at(S_RCNT, 64, "ovf_rcnt", 0);
    expect_at(S_ERR, 3'b001, "ovf_err", 0);
    rd(0, 63, 64, "ovf_last_limb");
    rd(0, 0, 1, "ovf_first_limb");
    release_pulse();

    // Unknown type mid-packet into bank 1
    send(0, 5, 0); send(2, 7, 0); send(3'd6, 29'h1234, 0); send(2, 9, 0); send(4, 0, 1);
    expect_at(S_RCNT, 2, "unk_rcnt", 0);
    expect_at(S_ICNT, 0, "unk_icnt", 0);
    expect_at(S_ERR, 3'b011, "unk_err", 0);
    rd(0, 1, 9, "unk_real1");
    release_pulse();

    // Lone end-of-stream word: empty packet into bank 0, left FULL
    send(4, 0, 1);
    expect_at(S_OUT_VALID, 1, "empty_out_valid", 0);
    expect_at(S_RCNT, 0, "empty_rcnt", 0);
    expect_at(S_ERR, 3'b111, "empty_err", 0);
    idle(1);

    // Asynchronous reset after two limbs of a packet in bank 1
    send(2, 50, 0); send(2, 51, 0);
    #2;
    reset = 1'b1;
    expect_at(S_OUT_VALID, 0, "async_rst_out_valid", 0);
    expect_at(S_IN_READY, 1, "async_rst_in_ready", 0);
    expect_at(S_ERR, 0, "async_rst_err", 0);
    idle(1);
    reset = 1'b0;
    idle(1);

    // Fresh packet loads into bank 0 from index 0
    send(0, 40, 0); send(2, 11, 0); send(2, 12, 0); send(2, 13, 0); send(4, 0, 1);
    expect_at(S_ADDR, 40, "post_rst_addr", 0);
    expect_at(S_RCNT, 3, "post_rst_rcnt", 0);
    rd(0, 0, 11, "post_rst_real0");
    rd(0, 2, 13, "post_rst_real2");
`ifdef TILE_LOADER_ZERO_FILL_EN
    rd(0, 5, 0, "beyond_count_real5");
`else
    rd(0, 5, 6, "beyond_count_real5");
`endif
    idle(3);

    while (sb.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL unchecked_%s: never compared, expected 0x%0h", sb[0].name, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
